// File: rtl/chacha_ks_sequencer.sv
// Drives chacha_core through a run of consecutive keystream blocks and streams
// each 512-bit result out as sixteen 32-bit words on a valid/ready interface.
module chacha_ks_sequencer #(
  parameter int BLK_W    = 16,
  parameter bit PREFETCH = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [63:0]      ctr_start,
  input  logic [BLK_W-1:0] num_blocks,
  output logic             busy,
  output logic             done,
  output logic [BLK_W-1:0] blocks_done,
  output logic             core_init,
  output logic             core_next,
  output logic [63:0]      core_ctr,
  input  logic             core_ready,
  input  logic             core_data_out_valid,
  input  logic [511:0]     core_data_out,
  output logic [31:0]      ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             ks_last
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, HOLD, FIN} state_t;

  state_t           state;
  logic [BLK_W-1:0] nblk_q;
  logic [BLK_W-1:0] issued_q;
  logic [BLK_W-1:0] last_blk;
  logic [511:0]     buf_q;
  logic [3:0]       idx_q;
  logic             xfer;
  logic             last_xfer;
  logic             can_capture;
  logic             more_to_issue;

  assign xfer          = ks_valid && ks_ready;
  assign last_xfer     = xfer && (idx_q == 4'd15);
  assign more_to_issue = issued_q < nblk_q;
  assign last_blk      = nblk_q - BLK_W'(1);

  // A full buffer may be refilled in the very cycle its final word leaves.
  assign can_capture = core_ready && core_data_out_valid && (!ks_valid || last_xfer);

  // (15-idx)*32 is the LSB of word idx, so word 0 is bits [511:480].
  assign ks_data = buf_q[{~idx_q, 5'd0} +: 32];
  assign ks_last = ks_valid && (idx_q == 4'd15) && (blocks_done == last_blk);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      nblk_q      <= '0;
      issued_q    <= '0;
      // NOTE: the block buffer is reset too, so ks_data reads 0 straight out of reset.
      buf_q       <= '0;
      idx_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      blocks_done <= '0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      core_ctr    <= '0;
      ks_valid    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; only the transition that needs one raises it.
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;

      if (xfer) begin
        idx_q <= idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          ks_valid    <= 1'b0;
          blocks_done <= blocks_done + BLK_W'(1);
        end
      end

      if (state == WAIT && can_capture) begin
        buf_q    <= core_data_out;
        idx_q    <= '0;
        ks_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            core_ctr    <= ctr_start;
            nblk_q      <= num_blocks;
            busy        <= 1'b1;
            issued_q    <= '0;
            blocks_done <= '0;
            if (num_blocks == '0) begin
              state <= FIN;
            end else begin
              state     <= ISSUE;
              core_init <= 1'b1;
            end
          end
        end
        ISSUE: begin
          issued_q <= issued_q + BLK_W'(1);
          state    <= SETTLE;
        end
        SETTLE: state <= WAIT;
        WAIT: begin
          if (can_capture) begin
            if (more_to_issue && PREFETCH) begin
              state     <= ISSUE;
              core_next <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (more_to_issue) begin
            if (!ks_valid || last_xfer) begin
              state     <= ISSUE;
              core_next <= 1'b1;
            end
          end else if (last_xfer) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          // Zero-length runs arrive here still busy and raise done now.
          state <= IDLE;
          if (busy) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (abort && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        core_init <= 1'b0;
        core_next <= 1'b0;
        ks_valid  <= 1'b0;
        buf_q     <= '0;
        idx_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_chacha_ks_sequencer.sv
// Directed bench for chacha_ks_sequencer with a small behavioural chacha_core
// stand-in; table-driven runs plus abort and reset sequences.
module tb_chacha_ks_sequencer;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic [63:0]   ctr_start;
  logic [15:0]   num_blocks;
  logic          busy, done;
  logic [15:0]   blocks_done;
  logic          core_init, core_next;
  logic [63:0]   core_ctr;
  logic          core_ready, core_data_out_valid;
  logic [511:0]  core_data_out;
  logic [31:0]   ks_data;
  logic          ks_valid, ks_ready, ks_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chacha_ks_sequencer #(.BLK_W(16), .PREFETCH(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .ctr_start(ctr_start), .num_blocks(num_blocks), .busy(busy), .done(done),
    .blocks_done(blocks_done), .core_init(core_init), .core_next(core_next),
    .core_ctr(core_ctr), .core_ready(core_ready),
    .core_data_out_valid(core_data_out_valid), .core_data_out(core_data_out),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_last(ks_last)
  );

  function automatic logic [31:0] pat(input logic [63:0] c, input int w);
    logic [7:0] wb;
    wb = 8'(w);
    return {c[15:0] ^ 16'h5a5a, wb, c[7:0] + wb};
  endfunction

  function automatic logic [511:0] make_block(input logic [63:0] c);
    logic [511:0] b;
    for (int w = 0; w < 16; w++) b[511-32*w -: 32] = pat(c, w);
    return b;
  endfunction

  // Core stand-in: init loads the counter, next advances it; result after 4 cycles.
  logic [63:0] m_blk;
  int          m_lat;
  always @(posedge clk) begin
    if (!reset_n) begin
      core_ready          <= 1'b1;
      core_data_out_valid <= 1'b0;
      core_data_out       <= '0;
      m_lat               <= 0;
      m_blk               <= '0;
    end else if (core_init || core_next) begin
      m_blk               <= core_init ? core_ctr : m_blk + 64'd1;
      core_ready          <= 1'b0;
      core_data_out_valid <= 1'b0;
      m_lat               <= 4;
    end else if (m_lat > 0) begin
      m_lat <= m_lat - 1;
      if (m_lat == 1) begin
        core_ready          <= 1'b1;
        core_data_out_valid <= 1'b1;
        core_data_out       <= make_block(m_blk);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int          nblk;
    logic [63:0] ctr;
    bit          toggle;          // ks_ready 1010... instead of always 1
    int          stall;           // cycles of ks_ready=0 after first word appears
    bit          spam;            // hold start high with other values while busy
    int          exp_init;
    int          exp_next;
    int          exp_stall_next;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, nw, ni, nn, sn, nd, dcyc, hcyc, stall_left;
    bit seen, ctr_bad, last_bad, both_bad, stall_bad, busy_bad;
    logic [31:0] hold_w;
    nw = 0; ni = 0; nn = 0; sn = 0; nd = 0; dcyc = -1; hcyc = -1;
    seen = 0; ctr_bad = 0; last_bad = 0; both_bad = 0; stall_bad = 0; busy_bad = 0;
    hold_w = '0;
    stall_left = v.stall;
    @(negedge clk);
    cyc = 0;
    while (cyc < 3000 && !(dcyc >= 0 && cyc > dcyc + 3)) begin
      start      = (cyc == 0) || (v.spam && cyc >= 2 && busy);
      ctr_start  = (cyc == 0) ? v.ctr : ~v.ctr;
      num_blocks = (cyc == 0) ? 16'(v.nblk) : 16'(v.nblk + 5);
      if (ks_valid && !seen) begin
        seen   = 1;
        hold_w = ks_data;
      end
      if (seen && stall_left > 0) begin
        ks_ready = 1'b0;
        stall_left--;
        if (!ks_valid || ks_data !== hold_w) stall_bad = 1;
        if (core_next) sn++;
      end else begin
        ks_ready = v.toggle ? ~cyc[0] : 1'b1;
      end
      if (core_init) ni++;
      if (core_next) nn++;
      if (core_init && core_next) both_bad = 1;
      if (done) begin
        nd++;
        dcyc = cyc;
        if (busy) busy_bad = 1;
      end
      if (cyc >= 1 && core_ctr !== v.ctr) ctr_bad = 1;
      if (ks_last && !ks_valid) last_bad = 1;
      if (ks_valid && ks_ready) begin
        check($sformatf("%s word %0d", tag, nw), ks_data, pat(v.ctr + 64'(nw / 16), nw % 16));
        if (ks_last !== (nw == 16 * v.nblk - 1)) last_bad = 1;
        hcyc = cyc;
        nw++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ks_ready = 1'b0;
    check({tag, " done count"}, nd, 1);
    check({tag, " done latency"}, dcyc, (v.nblk == 0) ? 2 : hcyc + 1);
    check({tag, " word count"}, nw, 16 * v.nblk);
    check({tag, " init pulses"}, ni, v.exp_init);
    check({tag, " next pulses"}, nn, v.exp_next);
    check({tag, " blocks_done"}, blocks_done, v.nblk);
    check({tag, " core_ctr held"}, ctr_bad, 0);
    check({tag, " ks_last"}, last_bad, 0);
    check({tag, " pulse overlap"}, both_bad, 0);
    check({tag, " busy low with done"}, busy_bad, 0);
    if (v.stall > 0) begin
      check({tag, " stall stable"}, stall_bad, 0);
      check({tag, " stall next pulses"}, sn, v.exp_stall_next);
    end
  endtask

  vec_t vecs[5];
  vec_t restart_v;

  initial begin
    int nw, guard, nd;
    bit vbad;

    vecs[0] = '{nblk: 1, ctr: 64'h0000_0000_0000_1234, toggle: 0, stall: 0,  spam: 0, exp_init: 1, exp_next: 0, exp_stall_next: 0};
    vecs[1] = '{nblk: 3, ctr: 64'h0000_0000_0000_0007, toggle: 1, stall: 0,  spam: 0, exp_init: 1, exp_next: 2, exp_stall_next: 0};
    vecs[2] = '{nblk: 2, ctr: 64'h0000_0001_0000_00f0, toggle: 0, stall: 40, spam: 0, exp_init: 1, exp_next: 1, exp_stall_next: 1};
    vecs[3] = '{nblk: 0, ctr: 64'h0000_0000_0000_0055, toggle: 0, stall: 0,  spam: 0, exp_init: 0, exp_next: 0, exp_stall_next: 0};
    vecs[4] = '{nblk: 3, ctr: 64'h0000_0000_0000_0a00, toggle: 1, stall: 0,  spam: 1, exp_init: 1, exp_next: 2, exp_stall_next: 0};
    restart_v = '{nblk: 1, ctr: 64'h0000_0000_0000_0321, toggle: 0, stall: 0, spam: 0, exp_init: 1, exp_next: 0, exp_stall_next: 0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    ctr_start = '0; num_blocks = '0;
    repeat (3) @(negedge clk);
    check("reset flags", {busy, done, core_init, core_next, ks_valid, ks_last}, 6'b0);
    check("reset blocks_done", blocks_done, 0);
    check("reset ks_data", ks_data, 0);
    check("reset core_ctr", core_ctr, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort while word 7 of block 2 (of 4) is on the bus.
    @(negedge clk);
    start = 1'b1; ctr_start = 64'h100; num_blocks = 16'd4; ks_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nw = 0; guard = 0;
    while (!(ks_valid && nw == 39) && guard < 2000) begin
      if (ks_valid && ks_ready) nw++;
      @(negedge clk);
      guard++;
    end
    check("abort reached word 39", guard < 2000, 1);
    check("abort word value", ks_data, pat(64'h102, 7));
    abort = 1'b1; ks_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort flags", {ks_valid, busy, done}, 3'b000);
    nd = 0; vbad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
      if (ks_valid || busy) vbad = 1;
    end
    check("abort no done", nd, 0);
    check("abort stays idle", vbad, 0);
    run_vec(restart_v, "restart");

    // Synchronous reset mid-drain.
    @(negedge clk);
    start = 1'b1; ctr_start = 64'habcd; num_blocks = 16'd2; ks_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nw = 0; guard = 0;
    while (nw < 5 && guard < 2000) begin
      if (ks_valid && ks_ready) nw++;
      @(negedge clk);
      guard++;
    end
    check("reset test reached drain", guard < 2000, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; ks_ready = 1'b0;
    check("mid reset flags", {busy, done, core_init, core_next, ks_valid, ks_last}, 6'b0);
    check("mid reset blocks_done", blocks_done, 0);
    check("mid reset ks_data", ks_data, 0);
    check("mid reset core_ctr", core_ctr, 0);
    run_vec(restart_v, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
